// File: rtl/it2_fuzzy_pkg.sv
// Shared types and width helpers for the IT2 fuzzy inference engine.
package it2_fuzzy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_ACCUM,
    ST_DIVIDE,
    ST_DONE
  } fsm_e;

  // Ceiling log2, never below 1 so every derived field has a legal width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Consequent index width (CW).
  function automatic int cw_of(input int ncons);
    return clog2(ncons);
  endfunction

  // Rule index width (RW).
  function automatic int rw_of(input int nsets);
    return clog2(nsets * nsets);
  endfunction

  // Numerator width: (up+low)*c summed over NCONS consequents.
  function automatic int numw_of(input int w, input int ncons);
    return 2 * w + 1 + clog2(ncons);
  endfunction

  // Denominator width: (up+low) summed over NCONS consequents.
  function automatic int denw_of(input int w, input int ncons);
    return w + 1 + clog2(ncons);
  endfunction

  // Widths for the default configuration (W=8, NSETS=3, NCONS=3).
  localparam int DEF_CW   = cw_of(3);
  localparam int DEF_RW   = rw_of(3);
  localparam int DEF_NUMW = numw_of(8, 3);
  localparam int DEF_DENW = denw_of(8, 3);

endpackage

// File: rtl/it2_seq_divider.sv
// Restoring divider: W-bit floor quotient of num/den in exactly W cycles.
// The caller guarantees num < den << W, so the quotient cannot overflow.
module it2_seq_divider
  import it2_fuzzy_pkg::*;
#(
  parameter int W    = 8,
  parameter int NUMW = 19,
  parameter int DENW = 11
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [NUMW-1:0] num_i,
  input  logic [DENW-1:0] den_i,
  output logic [W-1:0]    quo_o,
  output logic            done_o
);

  localparam int SW = clog2(W);

  logic [NUMW-1:0] rem_q, dvs_q;
  logic [W-1:0]    quo_q;
  logic [SW-1:0]   cnt_q;
  logic            run_q, done_q;

  logic [NUMW-1:0] cur_rem, cur_dvs, nxt_rem;
  logic            ge;

  // The start cycle already performs the first (MSB) step on the fresh operands.
  always_comb begin
    cur_rem = start_i ? num_i : rem_q;
    cur_dvs = start_i ? (NUMW'(den_i) << (W - 1)) : dvs_q;
    ge      = (cur_rem >= cur_dvs);
    nxt_rem = ge ? (cur_rem - cur_dvs) : cur_rem;
  end

  // One quotient bit per cycle, MSB first; done pulses after the W-th bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q <= nxt_rem;
        dvs_q <= cur_dvs >> 1;
        quo_q <= {{(W-1){1'b0}}, ge};
        cnt_q <= SW'(1);
        run_q <= 1'b1;
      end else if (run_q) begin
        rem_q <= nxt_rem;
        dvs_q <= cur_dvs >> 1;
        quo_q <= {quo_q[W-2:0], ge};
        if (cnt_q == SW'(W - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + SW'(1);
        end
      end
    end
  end

  assign quo_o  = quo_q;
  assign done_o = done_q;

endmodule

// File: rtl/it2_fuzzy_engine.sv
// Interval type-2 fuzzy inference: min/max rule sweep over NSETS x NSETS
// rules, then Nie-Tan defuzzification y = sum((up+low)*c) / sum(up+low).
module it2_fuzzy_engine
  import it2_fuzzy_pkg::*;
#(
  parameter int W         = 8,
  parameter int NSETS     = 3,
  parameter int NCONS     = 3,
  parameter int SKIP_ZERO = 0
) (
  input  logic                                  clk_0,
  input  logic                                  Srst,
  input  logic                                  start,
  input  logic [NSETS*W-1:0]                    mu_up_a,
  input  logic [NSETS*W-1:0]                    mu_low_a,
  input  logic [NSETS*W-1:0]                    mu_up_b,
  input  logic [NSETS*W-1:0]                    mu_low_b,
  input  logic [NSETS*NSETS*cw_of(NCONS)-1:0]   rule_cons,
  input  logic [NCONS*W-1:0]                    centroid,
  output logic                                  busy,
  output logic                                  done,
  output logic [W-1:0]                          y,
  output logic                                  div_zero,
  output logic [NCONS*W-1:0]                    agg_up,
  output logic [NCONS*W-1:0]                    agg_low,
  output logic [rw_of(NSETS)-1:0]               rule_idx
);

  localparam int NR   = NSETS * NSETS;
  localparam int CW   = cw_of(NCONS);
  localparam int RW   = rw_of(NSETS);
  localparam int NUMW = numw_of(W, NCONS);
  localparam int DENW = denw_of(W, NCONS);

  typedef logic [W-1:0] deg_t;

  // Port views and input-sanity clamp (low never above up).
  deg_t [NSETS-1:0]        in_up_a, in_low_a, in_up_b, in_low_b;
  deg_t [NSETS-1:0]        cl_low_a, cl_low_b;
  logic [NR-1:0][CW-1:0]   in_cons;
  deg_t [NCONS-1:0]        in_cent;

  assign in_up_a  = mu_up_a;
  assign in_low_a = mu_low_a;
  assign in_up_b  = mu_up_b;
  assign in_low_b = mu_low_b;
  assign in_cons  = rule_cons;
  assign in_cent  = centroid;

  for (genvar s = 0; s < NSETS; s++) begin : g_clamp
    assign cl_low_a[s] = (in_low_a[s] > in_up_a[s]) ? in_up_a[s] : in_low_a[s];
    assign cl_low_b[s] = (in_low_b[s] > in_up_b[s]) ? in_up_b[s] : in_low_b[s];
  end

  // Run-time state
  fsm_e                  state_q;
  deg_t [NSETS-1:0]      up_a_q, low_a_q, up_b_q, low_b_q;
  logic [NR-1:0][CW-1:0] cons_q;
  deg_t [NCONS-1:0]      cent_q, agg_up_q, agg_low_q;
  logic [RW-1:0]         rule_q;
  logic [CW-1:0]         k_q;
  logic [NUMW-1:0]       num_q;
  logic [DENW-1:0]       den_q;
  deg_t                  y_q;
  logic                  dz_q, busy_q, done_q, div_go_q;

  // Per-rule firing strengths and activity masks (port side for the first
  // jump target, latched side for the sweep itself).
  deg_t [NR-1:0] str_up, str_low;
  logic [NR-1:0] act_p, act_q;

  for (genvar r = 0; r < NR; r++) begin : g_rule
    localparam int I = r / NSETS;
    localparam int J = r % NSETS;
    assign str_up[r]  = (up_a_q[I]  < up_b_q[J])  ? up_a_q[I]  : up_b_q[J];
    assign str_low[r] = (low_a_q[I] < low_b_q[J]) ? low_a_q[I] : low_b_q[J];
    assign act_p[r]   = (in_up_a[I] != '0) && (in_up_b[J] != '0);
    assign act_q[r]   = (up_a_q[I]  != '0) && (up_b_q[J]  != '0);
  end

  // Priority encoders: first active rule at request time, next rule after rule_q.
  logic [RW-1:0] first_idx, nxt_idx;
  logic          nxt_found, do_rule;

  always_comb begin
    first_idx = '0;
    nxt_idx   = '0;
    nxt_found = 1'b0;
    for (int r = NR - 1; r >= 0; r--) begin
      if (act_p[r]) first_idx = RW'(r);
      if (((SKIP_ZERO == 0) || act_q[r]) && (RW'(r) > rule_q)) begin
        nxt_found = 1'b1;
        nxt_idx   = RW'(r);
      end
    end
    do_rule = (SKIP_ZERO == 0) || act_q[rule_q];
  end

  // Accumulation term for consequent k_q.
  logic [W:0]     sum_k;
  logic [2*W:0]   prod_k;

  always_comb begin
    sum_k  = {1'b0, agg_up_q[k_q]} + {1'b0, agg_low_q[k_q]};
    prod_k = {{W{1'b0}}, sum_k} * {{(W+1){1'b0}}, cent_q[k_q]};
  end

  logic [W-1:0] quo;
  logic         div_done;

  it2_seq_divider #(
    .W    (W),
    .NUMW (NUMW),
    .DENW (DENW)
  ) u_div (
    .clk_i   (clk_0),
    .rst_ni  (Srst),
    .start_i (div_go_q),
    .num_i   (num_q),
    .den_i   (den_q),
    .quo_o   (quo),
    .done_o  (div_done)
  );

  // Main FSM with all datapath registers and registered outputs.
  always_ff @(posedge clk_0 or negedge Srst) begin
    if (!Srst) begin
      state_q   <= ST_IDLE;
      up_a_q    <= '0;
      low_a_q   <= '0;
      up_b_q    <= '0;
      low_b_q   <= '0;
      cons_q    <= '0;
      cent_q    <= '0;
      agg_up_q  <= '0;
      agg_low_q <= '0;
      rule_q    <= '0;
      k_q       <= '0;
      num_q     <= '0;
      den_q     <= '0;
      y_q       <= '0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div_go_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      div_go_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            up_a_q    <= in_up_a;
            low_a_q   <= cl_low_a;
            up_b_q    <= in_up_b;
            low_b_q   <= cl_low_b;
            cons_q    <= in_cons;
            cent_q    <= in_cent;
            agg_up_q  <= '0;
            agg_low_q <= '0;
            num_q     <= '0;
            den_q     <= '0;
            k_q       <= '0;
            rule_q    <= (SKIP_ZERO != 0) ? first_idx : '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SWEEP;
          end
        end
        ST_SWEEP: begin
          for (int k = 0; k < NCONS; k++) begin
            if (do_rule && (cons_q[rule_q] == CW'(k))) begin
              if (str_up[rule_q]  > agg_up_q[k])  agg_up_q[k]  <= str_up[rule_q];
              if (str_low[rule_q] > agg_low_q[k]) agg_low_q[k] <= str_low[rule_q];
            end
          end
          if (nxt_found) rule_q  <= nxt_idx;
          else           state_q <= ST_ACCUM;
        end
        ST_ACCUM: begin
          den_q <= den_q + {{(DENW-W-1){1'b0}}, sum_k};
          num_q <= num_q + {{(NUMW-2*W-1){1'b0}}, prod_k};
          if (k_q == CW'(NCONS - 1)) begin
            state_q  <= ST_DIVIDE;
            div_go_q <= 1'b1;
          end else begin
            k_q <= k_q + CW'(1);
          end
        end
        ST_DIVIDE: begin
          // The divider runs even for den==0 to keep latency constant;
          // its quotient is discarded in that case.
          if (div_done) begin
            y_q     <= (den_q == '0) ? '0 : quo;
            dz_q    <= (den_q == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign y        = y_q;
  assign div_zero = dz_q;
  assign agg_up   = agg_up_q;
  assign agg_low  = agg_low_q;
  assign rule_idx = rule_q;

endmodule

// File: tb/tb_it2_fuzzy_engine.sv
// Bench for it2_fuzzy_engine: one full-sweep and one skip-zero instance
// driven in lockstep and compared against a set-level reference model.
module tb_it2_fuzzy_engine;
  localparam int W  = 8;
  localparam int NS = 3;
  localparam int NC = 3;
  localparam int NR = NS * NS;
  localparam int CW = 2;
  localparam int RW = 4;
  localparam int MW = NS * W;

  logic clk_0 = 1'b0;
  logic Srst  = 1'b0;
  logic start = 1'b0;
  logic [MW-1:0]    mu_up_a, mu_low_a, mu_up_b, mu_low_b;
  logic [NR*CW-1:0] rule_cons;
  logic [NC*W-1:0]  centroid;

  logic busy0, done0, dz0, busy1, done1, dz1;
  logic [W-1:0]    y0, y1;
  logic [NC*W-1:0] aup0, alow0, aup1, alow1;
  logic [RW-1:0]   ridx0, ridx1;

  it2_fuzzy_engine #(.W(W), .NSETS(NS), .NCONS(NC), .SKIP_ZERO(0)) dut0 (
    .clk_0(clk_0), .Srst(Srst), .start(start),
    .mu_up_a(mu_up_a), .mu_low_a(mu_low_a), .mu_up_b(mu_up_b), .mu_low_b(mu_low_b),
    .rule_cons(rule_cons), .centroid(centroid),
    .busy(busy0), .done(done0), .y(y0), .div_zero(dz0),
    .agg_up(aup0), .agg_low(alow0), .rule_idx(ridx0));

  it2_fuzzy_engine #(.W(W), .NSETS(NS), .NCONS(NC), .SKIP_ZERO(1)) dut1 (
    .clk_0(clk_0), .Srst(Srst), .start(start),
    .mu_up_a(mu_up_a), .mu_low_a(mu_low_a), .mu_up_b(mu_up_b), .mu_low_b(mu_low_b),
    .rule_cons(rule_cons), .centroid(centroid),
    .busy(busy1), .done(done1), .y(y1), .div_zero(dz1),
    .agg_up(aup1), .agg_low(alow1), .rule_idx(ridx1));

  always #5 clk_0 = ~clk_0;

  int ua[NS], la[NS], ub[NS], lb[NS], rc[NR], cc[NC];
  int eu[NC], el[NC], ey, edz, nact, elast1;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int s = 0; s < NS; s++) begin
      mu_up_a[s*W +: W]  = W'(ua[s]);
      mu_low_a[s*W +: W] = W'(la[s]);
      mu_up_b[s*W +: W]  = W'(ub[s]);
      mu_low_b[s*W +: W] = W'(lb[s]);
    end
    for (int r = 0; r < NR; r++) rule_cons[r*CW +: CW] = CW'(rc[r]);
    for (int k = 0; k < NC; k++) centroid[k*W +: W] = W'(cc[k]);
  endtask

  // Reference: rule table evaluated set by set, Nie-Tan by integer division.
  task automatic model();
    int num, den, lac, lbc, su, sl, k;
    for (int q = 0; q < NC; q++) begin eu[q] = 0; el[q] = 0; end
    nact = 0; elast1 = 0;
    for (int i = 0; i < NS; i++)
      for (int j = 0; j < NS; j++) begin
        lac = (la[i] > ua[i]) ? ua[i] : la[i];
        lbc = (lb[j] > ub[j]) ? ub[j] : lb[j];
        su  = (ua[i] < ub[j]) ? ua[i] : ub[j];
        sl  = (lac < lbc) ? lac : lbc;
        k   = rc[i*NS + j];
        if (su > eu[k]) eu[k] = su;
        if (sl > el[k]) el[k] = sl;
        if (ua[i] != 0 && ub[j] != 0) begin nact++; elast1 = i*NS + j; end
      end
    num = 0; den = 0;
    for (int q = 0; q < NC; q++) begin
      den += eu[q] + el[q];
      num += (eu[q] + el[q]) * cc[q];
    end
    edz = (den == 0);
    ey  = (den == 0) ? 0 : num / den;
  endtask

  task automatic clear_stim();
    for (int s = 0; s < NS; s++) begin ua[s] = 0; la[s] = 0; ub[s] = 0; lb[s] = 0; end
    for (int r = 0; r < NR; r++) rc[r] = r % NC;
    cc[0] = 64; cc[1] = 128; cc[2] = 192;
  endtask

  task automatic set_t3();
    clear_stim();
    ua[0] = 100; la[0] = 100; ub[0] = 100; lb[0] = 100; ub[2] = 100; lb[2] = 100;
  endtask

  task automatic run(input string nm, input bit disturb);
    int lat0, lat1, nsk;
    drive();
    model();
    @(negedge clk_0); start = 1'b1;
    @(posedge clk_0); #1 start = 1'b0;
    lat0 = -1; lat1 = -1;
    for (int c = 1; c <= 60 && (lat0 < 0 || lat1 < 0); c++) begin
      @(posedge clk_0); #1;
      if (c == 1) chk({nm, ".busy_run"}, int'(busy0), 1);
      if (disturb && c == 3) begin
        mu_up_a = MW'($urandom); mu_low_a = MW'($urandom);
        mu_up_b = MW'($urandom); mu_low_b = MW'($urandom);
        centroid = (NC*W)'($urandom); start = 1'b1;
      end
      if (disturb && c == 5) start = 1'b0;
      if (done0 && lat0 < 0) begin lat0 = c; chk({nm, ".busy_done"}, int'(busy0), 0); end
      if (done1 && lat1 < 0) lat1 = c;
    end
    nsk = (nact > 0) ? nact : 1;
    chk({nm, ".lat0"}, lat0, NR + NC + W + 1);
    chk({nm, ".lat1"}, lat1, nsk + NC + W + 1);
    chk({nm, ".y0"}, int'(y0), ey);
    chk({nm, ".y1"}, int'(y1), ey);
    chk({nm, ".dz0"}, int'(dz0), edz);
    chk({nm, ".dz1"}, int'(dz1), edz);
    for (int k = 0; k < NC; k++) begin
      chk($sformatf("%s.aup0[%0d]", nm, k),  int'(aup0[k*W +: W]),  eu[k]);
      chk($sformatf("%s.alow0[%0d]", nm, k), int'(alow0[k*W +: W]), el[k]);
      chk($sformatf("%s.aup1[%0d]", nm, k),  int'(aup1[k*W +: W]),  eu[k]);
      chk($sformatf("%s.alow1[%0d]", nm, k), int'(alow1[k*W +: W]), el[k]);
    end
    chk({nm, ".ridx0"}, int'(ridx0), NR - 1);
    chk({nm, ".ridx1"}, int'(ridx1), elast1);
    @(posedge clk_0); #1;
    chk({nm, ".done_pulse"}, int'(done0), 0);
  endtask

  initial begin
    int ndone;
    clear_stim();
    drive();
    #12;
    chk("rst.busy", int'(busy0 | busy1), 0);
    chk("rst.done", int'(done0 | done1), 0);
    chk("rst.y", int'(y0 | y1), 0);
    chk("rst.dz", int'(dz0 | dz1), 0);
    chk("rst.agg", int'(|{aup0, alow0, aup1, alow1}), 0);
    chk("rst.ridx", int'(ridx0 | ridx1), 0);
    @(negedge clk_0); Srst = 1'b1;

    // all degrees zero -> divide by zero path
    clear_stim();
    run("t1", 1'b0);

    // single active rule
    clear_stim();
    ua[0] = 200; la[0] = 150; ub[1] = 100; lb[1] = 80; rc[1] = 2; cc[2] = 192;
    run("t2", 1'b0);

    // two rules, mean of 64 and 192
    set_t3();
    run("t3", 1'b0);

    // disturbance while busy plus clamped lower degrees
    clear_stim();
    ua[0] = 200; la[0] = 250; ub[1] = 220; lb[1] = 230; rc[1] = 2; cc[2] = 192;
    run("t6", 1'b1);

    // reset during DIVIDE
    set_t3();
    drive();
    @(negedge clk_0); start = 1'b1;
    @(posedge clk_0); #1 start = 1'b0;
    repeat (15) @(posedge clk_0);
    #2 Srst = 1'b0;
    #1;
    chk("t5.busy", int'(busy0), 0);
    chk("t5.y", int'(y0), 0);
    chk("t5.agg", int'(|{aup0, alow0}), 0);
    repeat (2) @(negedge clk_0);
    Srst = 1'b1;
    ndone = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk_0); #1;
      if (done0 || done1) ndone++;
    end
    chk("t5.no_done", ndone, 0);
    run("t5b", 1'b0);

    // randomized runs
    for (int n = 0; n < 10; n++) begin
      for (int s = 0; s < NS; s++) begin
        ua[s] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
        ub[s] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
        la[s] = int'($urandom_range(0, 255));
        lb[s] = int'($urandom_range(0, 255));
      end
      for (int r = 0; r < NR; r++) rc[r] = int'($urandom_range(0, NC - 1));
      for (int k = 0; k < NC; k++) cc[k] = int'($urandom_range(0, 255));
      run($sformatf("rnd%0d", n), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
